peri: RTL and testbench

PERI -- requirements
Module: peri

---
 rtl/peri.sv | 106 ++++++++++
 tb/tb_peri.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/peri.sv
// Timer peripheral: scratch registers, a 64-bit mtime counter with compare
// and interrupt, and a single-cycle acknowledged register bus.
module peri (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        regw,
    input  logic        regr,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdat,
    output logic        timer_irq
);

    localparam logic [31:0] ID_VAL = 32'h5045_5249;

    localparam logic [5:0] A_SCR0   = 6'h00;
    localparam logic [5:0] A_SCR1   = 6'h01;
    localparam logic [5:0] A_MTLO   = 6'h02;
    localparam logic [5:0] A_MTHI   = 6'h03;
    localparam logic [5:0] A_CMPLO  = 6'h04;
    localparam logic [5:0] A_CMPHI  = 6'h05;
    localparam logic [5:0] A_CTRL   = 6'h06;
    localparam logic [5:0] A_STATUS = 6'h07;
    localparam logic [5:0] A_ID     = 6'h08;

    logic [31:0] scratch0;
    logic [31:0] scratch1;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  ctrl;
    logic        pend;
    logic [5:0]  idx;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rd_mux;
    logic        unused_adr;

    assign idx        = adr[7:2];
    assign unused_adr = ^{adr[31:8], adr[1:0]};

    // A simultaneous read and write performs the write only.
    assign wr_en = regw;
    assign rd_en = regr & ~regw;

    assign pend      = (mtime >= mtimecmp);
    assign timer_irq = pend & ctrl[1];

    always_comb begin
        rd_mux = 32'h0;
        case (idx)
            A_SCR0:   rd_mux = scratch0;
            A_SCR1:   rd_mux = scratch1;
            A_MTLO:   rd_mux = mtime[31:0];
            A_MTHI:   rd_mux = mtime[63:32];
            A_CMPLO:  rd_mux = mtimecmp[31:0];
            A_CMPHI:  rd_mux = mtimecmp[63:32];
            A_CTRL:   rd_mux = {30'h0, ctrl};
            A_STATUS: rd_mux = {31'h0, pend};
            A_ID:     rd_mux = ID_VAL;
            default:  rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            ack  <= 1'b0;
            rdat <= 32'h0;
        end else begin
            ack  <= regr | regw;
            rdat <= rd_en ? rd_mux : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            scratch0 <= 32'h0;
            scratch1 <= 32'h0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl     <= 2'b00;
        end else if (wr_en) begin
            case (idx)
                A_SCR0:  scratch0        <= wdata;
                A_SCR1:  scratch1        <= wdata;
                A_CMPLO: mtimecmp[31:0]  <= wdata;
                A_CMPHI: mtimecmp[63:32] <= wdata;
                A_CTRL:  ctrl            <= wdata[1:0];
                default: ;
            endcase
        end
    end

    // A write to either half wins over the increment; no carry that cycle.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mtime <= 64'h0;
        end else if (wr_en && idx == A_MTLO) begin
            mtime <= {mtime[63:32], wdata};
        end else if (wr_en && idx == A_MTHI) begin
            mtime <= {wdata, mtime[31:0]};
        end else if (ctrl[0]) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_peri.sv
// Directed bench for peri: bus protocol, register map, mtime counting,
// compare interrupt and asynchronous reset behaviour.
module tb_peri;

    logic        clk;
    logic        cpurst;
    logic        regw;
    logic        regr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdat;
    logic        timer_irq;

    int checks;
    int errors;

    peri dut (
        .clk       (clk),
        .cpurst    (cpurst),
        .regw      (regw),
        .regr      (regr),
        .adr       (adr),
        .wdata     (wdata),
        .ack       (ack),
        .rdat      (rdat),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        regw  = 1'b1;
        adr   = a;
        wdata = d;
        @(posedge clk);
        #1;
        regw = 1'b0;
        check("wr_ack", ack, 1);
        check("wr_rdat", rdat, 0);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        regr = 1'b1;
        adr  = a;
        @(posedge clk);
        #1;
        regr = 1'b0;
        check("rd_ack", ack, 1);
        d = rdat;
    endtask

    logic [31:0] v;

    initial begin
        checks = 0;
        errors = 0;
        cpurst = 1'b1;
        regw   = 1'b0;
        regr   = 1'b0;
        adr    = 32'h0;
        wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_rdat", rdat, 0);
        check("rst_irq", timer_irq, 0);

        // Request during reset is ignored
        @(negedge clk);
        regw  = 1'b1;
        adr   = 32'h0;
        wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        check("rst_req_ack", ack, 0);
        @(negedge clk);
        regw   = 1'b0;
        cpurst = 1'b0;

        // Write then read with one-cycle ack
        wr(32'h00, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("wr_ack_drop", ack, 0);
        rd(32'h00, v);
        check("scratch0", v, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("rd_ack_drop", ack, 0);
        check("rd_rdat_drop", rdat, 0);

        rd(32'h20, v);
        check("id", v, 32'h5045_5249);
        rd(32'h40, v);
        check("unmapped", v, 0);
        wr(32'h20, 32'h1234_5678);
        rd(32'h20, v);
        check("id_ro", v, 32'h5045_5249);
        rd(32'h1000_0023, v);
        check("adr_ignored", v, 32'h5045_5249);

        // Back-to-back reads
        @(negedge clk);
        regr = 1'b1;
        adr  = 32'h00;
        @(posedge clk);
        #1;
        check("b2b_ack0", ack, 1);
        check("b2b_rdat0", rdat, 32'hDEAD_BEEF);
        adr = 32'h20;
        @(posedge clk);
        #1;
        regr = 1'b0;
        check("b2b_ack1", ack, 1);
        check("b2b_rdat1", rdat, 32'h5045_5249);

        wr(32'h18, 32'hFFFF_FFFE);
        rd(32'h18, v);
        check("ctrl_mask", v, 32'h2);

        // Carry from MTIME_LO into MTIME_HI
        wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h0C, 32'h0);
        wr(32'h18, 32'h1);
        repeat (4) @(posedge clk);
        rd(32'h0C, v);
        check("mtime_carry", v, 32'h1);

        // Compare and interrupt
        wr(32'h18, 32'h0);
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h0);
        wr(32'h14, 32'h0);
        wr(32'h10, 32'd10);
        wr(32'h18, 32'h3);
        check("irq_t0", timer_irq, 0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("irq_t%0d", k), timer_irq, (k >= 10) ? 1 : 0);
        end
        rd(32'h1C, v);
        check("status_pend", v, 1);
        wr(32'h18, 32'h1);
        check("irq_masked", timer_irq, 0);
        rd(32'h1C, v);
        check("status_still", v, 1);

        // Simultaneous read and write
        @(negedge clk);
        regw  = 1'b1;
        regr  = 1'b1;
        adr   = 32'h04;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        regw = 1'b0;
        regr = 1'b0;
        check("rw_ack", ack, 1);
        check("rw_rdat", rdat, 0);
        rd(32'h04, v);
        check("rw_scratch1", v, 32'h55);

        // Reset mid-access
        @(negedge clk);
        regr = 1'b1;
        adr  = 32'h04;
        @(posedge clk);
        #1;
        regr = 1'b0;
        check("pre_rst_ack", ack, 1);
        #1;
        cpurst = 1'b1;
        #1;
        check("mid_rst_ack", ack, 0);
        check("mid_rst_rdat", rdat, 0);
        check("mid_rst_irq", timer_irq, 0);
        @(negedge clk);
        cpurst = 1'b0;
        rd(32'h10, v);
        check("rst_cmplo", v, 32'hFFFF_FFFF);
        rd(32'h14, v);
        check("rst_cmphi", v, 32'hFFFF_FFFF);
        rd(32'h18, v);
        check("rst_ctrl", v, 0);
        rd(32'h00, v);
        check("rst_scr0", v, 0);
        rd(32'h04, v);
        check("rst_scr1", v, 0);
        rd(32'h08, v);
        check("rst_mtlo", v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
